// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver (8N1) with valid/ready byte output and error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_os16 #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [32:0] INC = 33'(BAUD) << 4;
  localparam logic [32:0] LIM = 33'(CLK_HZ);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic        rx_p0, rx_p1, rxs, rxs_prev;
  logic [31:0] acc;
  logic [32:0] acc_sum;
  logic        tick;
  logic [2:0]  state;
  logic [3:0]  sc;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
`ifdef UART_RX_PARITY_EN
  logic        par_mis;
`endif

  assign rxs     = rx_p1;
  assign acc_sum = {1'b0, acc} + INC;

  // Synchronizer stage boundary: rx -> rx_p0 -> rx_p1 (rxs), plus edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_p0    <= rx;
      rx_p1    <= rx_p0;
      rxs_prev <= rx_p1;
    end
  end

  // Fractional-N tick generator: free-running, one tick per 1/16 bit on average
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_sum >= LIM) begin
      acc  <= 32'(acc_sum - LIM);
      tick <= 1'b1;
    end else begin
      acc  <= acc_sum[31:0];
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sc         <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_mis    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tick) sc <= sc + 4'd1;

      case (state)
        S_IDLE: begin
          if (rxs_prev && !rxs) begin
            state   <= S_START;
            sc      <= '0;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit
          if (tick && sc == 4'd7) begin
            sc <= '0;
            if (!rxs) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (tick && sc == 4'd15) begin
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_AFTER_DATA;
              sc    <= '0;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick && sc == 4'd15) begin
            par_mis <= rxs ^ (^shift);
            state   <= S_STOP;
            sc      <= '0;
          end
        end
`endif
        S_STOP: begin
          if (tick && sc == 4'd15) begin
            sc <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end else begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (par_mis) parity_err <= 1'b1;
              else
`endif
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state   <= S_IDLE;
            sc      <= '0;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          sc      <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at 3.2 MHz / 100 kbaud (32 clk per bit).
module tb_uart_rx_os16;
  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_busy = 0;
  logic [7:0] cap_data = 8'h00;

  uart_rx_os16 #(.CLK_HZ(3200000), .BAUD(100000)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the falling edge; tests compare deltas
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      cap_data = rx_data;
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (parity_err) n_perr++;
    if (rx_busy) n_busy++;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h want 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", rx_valid); end
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", rx_busy); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %0b want 0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %0b want 0", overrun); end
    n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %0b want 0", parity_err); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_rx_byte();
    int v0 = n_valid, f0 = n_ferr, o0 = n_ovr, p0 = n_perr, b0 = n_busy;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (n_valid - v0 != 1) begin n_err++; $display("FAIL a5_valid_cycles: got %0d want 1", n_valid - v0); end
    n_vec++; if (cap_data !== 8'hA5) begin n_err++; $display("FAIL a5_data: got %0h want a5", cap_data); end
    n_vec++; if (n_ferr - f0 != 0) begin n_err++; $display("FAIL a5_ferr: got %0d want 0", n_ferr - f0); end
    n_vec++; if (n_ovr - o0 != 0) begin n_err++; $display("FAIL a5_ovr: got %0d want 0", n_ovr - o0); end
    n_vec++; if (n_perr - p0 != 0) begin n_err++; $display("FAIL a5_perr: got %0d want 0", n_perr - p0); end
    n_vec++; if (n_busy - b0 < 250) begin n_err++; $display("FAIL a5_busy_len: got %0d want >=250", n_busy - b0); end
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL a5_busy_end: got %0b want 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int v0 = n_valid, f0 = n_ferr, b0 = n_busy;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    n_vec++; if (n_busy - b0 == 0) begin n_err++; $display("FAIL glitch_busy_pulse: got %0d want >0", n_busy - b0); end
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end: got %0b want 0", rx_busy); end
    n_vec++; if (n_valid - v0 != 0) begin n_err++; $display("FAIL glitch_valid: got %0d want 0", n_valid - v0); end
    n_vec++; if (n_ferr - f0 != 0) begin n_err++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_frame_err();
    int v0 = n_valid, f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    repeat (BIT_CLK) @(posedge clk);
    #1;
    n_vec++; if (n_ferr - f0 != 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr - f0); end
    n_vec++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_break: got %0b want 1", rx_busy); end
    n_vec++; if (n_valid - v0 != 0) begin n_err++; $display("FAIL ferr_valid: got %0d want 0", n_valid - v0); end
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release: got %0b want 0", rx_busy); end
    n_vec++; if (n_ferr - f0 != 1) begin n_err++; $display("FAIL ferr_total: got %0d want 1", n_ferr - f0); end
  endtask

  task automatic test_overrun();
    int o0 = n_ovr;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_first_valid: got %0b want 1", rx_valid); end
    n_vec++; if (rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_first_data: got %0h want 11", rx_data); end
    send_frame(8'h22, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (n_ovr - o0 != 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr - o0); end
    n_vec++; if (rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_data_kept: got %0h want 11", rx_data); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held: got %0b want 1", rx_valid); end
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_clear: got %0b want 0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h77;
    int v0, f0;
    rx_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (16) @(posedge clk);
    #1;
    n_vec++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %0b want 1", rx_busy); end
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %0h want 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0b want 0", rx_valid); end
    n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %0b want 0", rx_busy); end
    n_vec++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_err++; $display("FAIL rstmid_errs: got %0b want 000", {frame_err, overrun, parity_err}); end
    repeat (64) @(posedge clk);
    #1;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h5A, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (n_valid - v0 != 1) begin n_err++; $display("FAIL after_rst_valid: got %0d want 1", n_valid - v0); end
    n_vec++; if (cap_data !== 8'h5A) begin n_err++; $display("FAIL after_rst_data: got %0h want 5a", cap_data); end
    n_vec++; if (n_ferr - f0 != 0) begin n_err++; $display("FAIL after_rst_ferr: got %0d want 0", n_ferr - f0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d = 8'h07;
    int v0 = n_valid, p0 = n_perr, f0 = n_ferr;
    rx_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (n_perr - p0 != 1) begin n_err++; $display("FAIL par_bad_pulses: got %0d want 1", n_perr - p0); end
    n_vec++; if (n_valid - v0 != 0) begin n_err++; $display("FAIL par_bad_valid: got %0d want 0", n_valid - v0); end
    n_vec++; if (n_ferr - f0 != 0) begin n_err++; $display("FAIL par_bad_ferr: got %0d want 0", n_ferr - f0); end
    v0 = n_valid;
    p0 = n_perr;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (n_valid - v0 != 1) begin n_err++; $display("FAIL par_ok_valid: got %0d want 1", n_valid - v0); end
    n_vec++; if (cap_data !== 8'h07) begin n_err++; $display("FAIL par_ok_data: got %0h want 07", cap_data); end
    n_vec++; if (n_perr - p0 != 0) begin n_err++; $display("FAIL par_ok_perr: got %0d want 0", n_perr - p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_rx_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver that recovers bytes from the asynchronous serial line and hands them to the core over a valid/ready handshake. It is the receiving end of the 8N1 link driven by the board's UART transmitter. It replaces single-sample-per-bit reception with start-bit validation, mid-bit sampling and stop-bit checking, and reports framing and overrun errors as single-cycle pulses.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s; 16*BAUD must be <= CLK_HZ
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  8  received byte, valid while rx_valid=1
- rx_valid  out  1  byte available; held until accepted
- rx_ready  in  1  consumer accepts byte when rx_valid & rx_ready
- rx_busy  out  1  high from start-edge detection until the frame ends or is aborted
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte completed while the holding register was full and not being accepted
- parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 when parity disabled)

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1. Detection uses the synchronized value rxs.
- Tick generator: 32-bit accumulator, reset 0. Each clk adds 16*BAUD. When the sum is >= CLK_HZ, CLK_HZ is subtracted and a one-cycle `tick` is asserted. The accumulator is free-running and never cleared outside reset.
- 4-bit sample counter `sc` counts ticks. Every state entry clears it.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: a falling edge on rxs (previous 1, current 0) moves to START and sets rx_busy.
  - START: on the tick where sc reaches 7 (8th tick), sample rxs. If rxs=0, go to DATA with bit index 0. If rxs=1, it is a false start: go to IDLE with no error.
  - DATA: on every 16th tick, sample rxs into the shift register, LSB first. After bit 7, go to PARITY if the macro is defined, else STOP.
  - PARITY: on the 16th tick, compare rxs against the even parity of the data; latch the mismatch. Then go to STOP.
  - STOP: on the 16th tick:
    - rxs=1 and no parity mismatch: deliver the byte and go to IDLE.
    - rxs=1 with parity mismatch: pulse parity_err, discard the byte, go to IDLE.
    - rxs=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. rx_busy stays high.
- Delivery:
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle, load rx_data and set rx_valid=1.
  - Otherwise pulse overrun, drop the new byte, and keep the old rx_data.
- rx_valid clears on the cycle after a handshake unless a new byte loads in that same cycle.
- Reset mid-frame: the FSM returns to IDLE at once and the partial byte is discarded.
- Reset values: rx_data=0x00, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, parity_err=0, all internal state 0 or IDLE.

## Timing
- Input latency: the synchronizer adds 2 clk.
- Sampling accuracy:
  - Start edge is detected within 1 clk.
  - Sample points fall at 8/16 of each bit, ±1 tick of jitter from the free-running accumulator.
  - Tolerated baud mismatch is about ±3%.
- rx_valid rises 1 clk after the stop-bit sample tick. Error pulses occur in that same cycle.
- rx_busy falls 1 clk after the stop-bit sample tick when the stop bit is 1.
- Back-to-back frames are supported with no idle gap: a start edge directly after a valid stop sample is detected.
- Throughput: one byte per 10 bit times (11 with parity). Consumer stalls longer than one frame cause overrun.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is 8E1; the PARITY state is present.
  - parity_err is driven.
  - A byte with a parity mismatch is not delivered.
- Undefined:
  - Frame is 8N1; no PARITY state.
  - parity_err is constant 0.

## Test plan
All scenarios use CLK_HZ=3200000, BAUD=100000: tick every 2 clk, 32 clk per bit.
- Send 0xA5 (8N1) with rx_ready=1 → rx_valid high for exactly 1 clk with rx_data=0xA5, no error pulses, rx_busy low afterwards.
- Low glitch on rx for 6 clk, then high → rx_busy pulses, FSM returns to IDLE, no rx_valid, no frame_err.
- Send 0x3C with stop bit 0, held low for 64 clk, then high → one frame_err pulse, rx_valid stays 0, rx_busy stays high until rx returns high.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_valid=1 with rx_data=0x11, one overrun pulse at the end of 0x22, rx_data still 0x11. Raising rx_ready for 1 clk then clears rx_valid.
- Assert rst for 1 clk during data bit 3 of 0x77 → all outputs return to reset values. A following 0x5A is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 → one parity_err pulse, no rx_valid. Send 0x07 with parity bit 1 → rx_data=0x07 is delivered.
